capture_ctrl: RTL and testbench

Sequencer for the analyzer's sample memory. It arms the capture, fills the pre-trigger buffer, and enters the primed state. It then qualifies the trigger, counts holdoff samples after the trigger, and freezes writes. When stopped, it walks the circular buffer from the oldest sample to the newest over a valid/ready read port. It sits between the host/config registers and the dual-port sample RAM; probe data goes straight to the RAM and never passes through this block.

---
 rtl/capture_ctrl.sv | 142 ++++++++++++++
 tb/tb_capture_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// Capture sequencer for the analyzer sample RAM: arm, pre-trigger fill, trigger
// qualification, post-trigger holdoff, then oldest-to-newest readout.
module capture_ctrl #(
  parameter int ADDR_WIDTH    = 10,
  parameter int HOLDOFF_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_arm,
  input  logic                     i_abort,
  input  logic                     i_sample_en,
  input  logic                     i_trigger,
  input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
  input  logic                     i_rd_start,
  input  logic                     i_rd_ready,
  output logic                     o_mem_we,
  output logic [ADDR_WIDTH-1:0]    o_mem_waddr,
  output logic                     o_rd_valid,
  output logic [ADDR_WIDTH-1:0]    o_rd_addr,
  output logic [ADDR_WIDTH-1:0]    o_trig_addr,
  output logic                     o_primed,
  output logic                     o_stopped,
  output logic                     o_done
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH-1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PRIMED, S_TRIG, S_STOPPED, S_READ
  } state_t;

  state_t                   r_state, w_next;
  logic [ADDR_WIDTH-1:0]    r_wp, r_rd_addr, r_trig_addr;
  logic [ADDR_WIDTH:0]      r_fill_cnt, r_rd_cnt;
  logic [HOLDOFF_WIDTH-1:0] r_hold, r_hold_cnt, w_hold_clamp, w_hold_inc;
  logic                     r_done;
  logic                     w_we, w_hs;

  // Holdoff is clamped so the trigger sample is never overwritten.
  always_comb begin
    if (32'(i_holdoff) > 32'(DEPTH-1)) w_hold_clamp = HOLDOFF_WIDTH'(DEPTH-1);
    else                               w_hold_clamp = i_holdoff;
  end

  assign w_hold_inc = r_hold_cnt + 1'b1;

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_arm) w_next = S_FILL;
      S_FILL:    if (w_we && r_fill_cnt == LAST) w_next = S_PRIMED;
      S_PRIMED:  if (w_we && i_trigger)
                   w_next = (w_hold_clamp == '0) ? S_STOPPED : S_TRIG;
      S_TRIG:    if (w_we && w_hold_inc == r_hold) w_next = S_STOPPED;
      S_STOPPED: if (i_rd_start) w_next = S_READ;
      S_READ:    if (w_hs && r_rd_cnt == LAST) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (i_abort) w_next = S_IDLE;
  end

  // output logic
  always_comb begin
    w_we       = 1'b0;
    o_rd_valid = 1'b0;
    o_primed   = 1'b0;
    o_stopped  = 1'b0;
    case (r_state)
      S_FILL, S_TRIG: w_we = i_sample_en;
      S_PRIMED: begin
        w_we     = i_sample_en;
        o_primed = 1'b1;
      end
      S_STOPPED: o_stopped = 1'b1;
      S_READ: begin
        o_stopped  = 1'b1;
        o_rd_valid = 1'b1;
      end
      default: ;
    endcase
    if (i_abort || reset) w_we = 1'b0;
    w_hs = o_rd_valid && i_rd_ready;
  end

  assign o_mem_we    = w_we;
  assign o_mem_waddr = r_wp;
  assign o_rd_addr   = r_rd_addr;
  assign o_trig_addr = r_trig_addr;
  assign o_done      = r_done;

  // datapath: pointers and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp        <= '0;
      r_rd_addr   <= '0;
      r_trig_addr <= '0;
      r_fill_cnt  <= '0;
      r_rd_cnt    <= '0;
      r_hold      <= '0;
      r_hold_cnt  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_we) r_wp <= r_wp + 1'b1;
      if (!i_abort) begin
        case (r_state)
          S_IDLE: if (i_arm) begin
            r_wp        <= '0;
            r_fill_cnt  <= '0;
            r_trig_addr <= '0;
          end
          S_FILL: if (w_we) r_fill_cnt <= r_fill_cnt + 1'b1;
          S_PRIMED: if (w_we && i_trigger) begin
            r_trig_addr <= r_wp;
            r_hold      <= w_hold_clamp;
            r_hold_cnt  <= '0;
          end
          S_TRIG: if (w_we) r_hold_cnt <= w_hold_inc;
          S_STOPPED: if (i_rd_start) begin
            r_rd_addr <= r_wp;
            r_rd_cnt  <= '0;
          end
          S_READ: if (w_hs) begin
            r_rd_addr <= r_rd_addr + 1'b1;
            r_rd_cnt  <= r_rd_cnt + 1'b1;
            if (r_rd_cnt == LAST) r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: directed scenarios push expected RAM
// writes, read handshakes and done pulses; a monitor pops and compares them.
module tb_capture_ctrl;
  localparam int AW = 4;
  localparam int HW = 10;

  logic          clk = 0, reset = 1;
  logic          i_arm = 0, i_abort = 0, i_sample_en = 0, i_trigger = 0;
  logic [HW-1:0] i_holdoff = '0;
  logic          i_rd_start = 0, i_rd_ready = 0;
  logic          o_mem_we, o_rd_valid, o_primed, o_stopped, o_done;
  logic [AW-1:0] o_mem_waddr, o_rd_addr, o_trig_addr;

  capture_ctrl #(.ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW)) dut (
    .clk(clk), .reset(reset), .i_arm(i_arm), .i_abort(i_abort),
    .i_sample_en(i_sample_en), .i_trigger(i_trigger), .i_holdoff(i_holdoff),
    .i_rd_start(i_rd_start), .i_rd_ready(i_rd_ready),
    .o_mem_we(o_mem_we), .o_mem_waddr(o_mem_waddr), .o_rd_valid(o_rd_valid),
    .o_rd_addr(o_rd_addr), .o_trig_addr(o_trig_addr), .o_primed(o_primed),
    .o_stopped(o_stopped), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_W, EV_R, EV_D} ev_kind_t;
  typedef struct packed { ev_kind_t kind; logic [AW-1:0] addr; } ev_t;
  ev_t q[$];
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_w(input int a); q.push_back('{EV_W, AW'(a)}); endtask
  task automatic exp_r(input int a); q.push_back('{EV_R, AW'(a)}); endtask
  task automatic exp_d(); q.push_back('{EV_D, '0}); endtask
  task automatic exp_w_range(input int a, input int n);
    for (int i = 0; i < n; i++) exp_w((a + i) % 16);
  endtask
  task automatic exp_r_range(input int a, input int n);
    for (int i = 0; i < n; i++) exp_r((a + i) % 16);
  endtask

  task automatic observe(input ev_kind_t k, input logic [AW-1:0] a);
    ev_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL sb_unexpected: got kind %0d addr %0d expected nothing", k, a);
    end else begin
      e = q.pop_front();
      if (e.kind !== k || e.addr !== a) begin
        n_bad++;
        $display("FAIL sb_event: got kind %0d addr %0d expected kind %0d addr %0d",
                 k, a, e.kind, e.addr);
      end
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (o_mem_we)                observe(EV_W, o_mem_waddr);
      if (o_rd_valid && i_rd_ready) observe(EV_R, o_rd_addr);
      if (o_done)                  observe(EV_D, '0);
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic ticks(input int n); for (int i = 0; i < n; i++) tick(); endtask
  task automatic arm(); i_arm = 1; tick(); i_arm = 0; endtask

  // Readout with ready held high; handshakes are pushed by the caller.
  task automatic read_all();
    i_rd_start = 1; tick(); i_rd_start = 0;
    i_rd_ready = 1; ticks(16); i_rd_ready = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    ticks(2);
    reset = 0;
    // reset state
    check("rst_we", o_mem_we, 0);      check("rst_waddr", o_mem_waddr, 0);
    check("rst_rdv", o_rd_valid, 0);   check("rst_rdaddr", o_rd_addr, 0);
    check("rst_trig", o_trig_addr, 0); check("rst_primed", o_primed, 0);
    check("rst_stopped", o_stopped, 0); check("rst_done", o_done, 0);

    // 1: holdoff 5, trigger at wp=3
    i_sample_en = 1; i_holdoff = 5;
    exp_w_range(0, 16); exp_w_range(0, 3); exp_w(3); exp_w_range(4, 5);
    arm();
    ticks(15); check("t1_primed_early", o_primed, 0);
    tick();    check("t1_primed", o_primed, 1);
    ticks(3);  i_trigger = 1; tick(); i_trigger = 0;
    check("t1_trig_addr", o_trig_addr, 3);
    ticks(4);  check("t1_stopped_early", o_stopped, 0);
    tick();    check("t1_stopped", o_stopped, 1);
    check("t1_wp", o_mem_waddr, 9);
    check("t1_we_stopped", o_mem_we, 0);
    i_arm = 1; tick(); i_arm = 0;
    check("t1_arm_ignored", o_stopped, 1);

    // 2: readout with ready toggling 1/0
    i_sample_en = 0;
    exp_r_range(9, 16); exp_d();
    i_rd_start = 1; tick(); i_rd_start = 0;
    check("t2_rdv", o_rd_valid, 1); check("t2_first", o_rd_addr, 9);
    for (int k = 0; k < 16; k++) begin
      i_rd_ready = 1; tick();
      i_rd_ready = 0;
      if (k < 15) begin
        check("t2_hold", o_rd_addr, (9 + k + 1) % 16);
        tick();
        check("t2_hold2", o_rd_addr, (9 + k + 1) % 16);
      end
    end
    check("t2_done", o_done, 1); check("t2_idle_rdv", o_rd_valid, 0);
    tick();
    check("t2_done_once", o_done, 0); check("t2_idle_stop", o_stopped, 0);
    check("t2_wp_kept", o_mem_waddr, 9); check("t2_trig_kept", o_trig_addr, 3);

    // 3: strobe every 3rd cycle, zero holdoff
    i_holdoff = 0;
    exp_w_range(0, 16); exp_w(0);
    arm();
    for (int c = 0; c < 48; c++) begin
      i_sample_en = (c % 3 == 2); tick();
      if (c == 46) check("t3_primed_early", o_primed, 0);
    end
    i_sample_en = 0;
    check("t3_primed", o_primed, 1);
    i_trigger = 1; tick();
    check("t3_trig_no_strobe", o_primed, 1);
    i_sample_en = 1; tick(); i_trigger = 0;
    check("t3_stopped", o_stopped, 1); check("t3_trig_addr", o_trig_addr, 0);
    check("t3_wp", o_mem_waddr, 1);
    ticks(3); i_sample_en = 0;
    exp_r_range(1, 16); exp_d();
    read_all();

    // 4: holdoff clamp, trigger during FILL ignored
    i_sample_en = 1; i_holdoff = 100;
    exp_w_range(0, 16); exp_w_range(0, 16);
    arm();
    i_trigger = 1; ticks(16); i_trigger = 0;
    check("t4_fill_trig_ignored", o_primed, 1);
    i_trigger = 1; tick(); i_trigger = 0;
    check("t4_trig_addr", o_trig_addr, 0);
    ticks(14); check("t4_stopped_early", o_stopped, 0);
    tick();    check("t4_stopped", o_stopped, 1);
    check("t4_wp_oldest", o_mem_waddr, 0);
    i_sample_en = 0;
    i_rd_start = 1; tick(); i_rd_start = 0;
    check("t4_first_is_trig", o_rd_addr, 0);
    exp_r_range(0, 16); exp_d();
    i_rd_ready = 1; ticks(16); i_rd_ready = 0; tick();

    // 5a: arm mid-fill ignored, abort in TRIG
    i_sample_en = 1; i_holdoff = 5;
    exp_w_range(0, 16); exp_w_range(0, 3);
    arm();
    ticks(5); i_arm = 1; tick(); i_arm = 0; ticks(10);
    check("t5_no_restart", o_primed, 1);
    i_trigger = 1; tick(); i_trigger = 0;
    ticks(2);
    i_abort = 1; #1;
    check("t5_abort_we", o_mem_we, 0);
    tick(); i_abort = 0;
    check("t5_abort_primed", o_primed, 0); check("t5_abort_stop", o_stopped, 0);
    i_rd_start = 1; tick(); i_rd_start = 0;
    check("t5_rdstart_ignored", o_rd_valid, 0);

    // 5b: abort in READ
    i_holdoff = 0;
    exp_w_range(0, 16); exp_w(0); exp_r_range(1, 3);
    arm();
    ticks(16); i_trigger = 1; tick(); i_trigger = 0; i_sample_en = 0;
    i_rd_start = 1; tick(); i_rd_start = 0;
    i_rd_ready = 1; ticks(3); i_rd_ready = 0;
    i_abort = 1; tick(); i_abort = 0;
    check("t5_read_abort_rdv", o_rd_valid, 0); check("t5_read_abort_done", o_done, 0);
    ticks(2); check("t5_no_done", o_done, 0);

    // 6: reset during READ
    i_sample_en = 1;
    exp_w_range(0, 16); exp_w_range(0, 3); exp_r_range(3, 2);
    arm();
    ticks(18); i_trigger = 1; tick(); i_trigger = 0; i_sample_en = 0;
    check("t6_trig_addr", o_trig_addr, 2);
    i_rd_start = 1; tick(); i_rd_start = 0;
    i_rd_ready = 1; ticks(2); i_rd_ready = 0;
    reset = 1; tick(); reset = 0;
    check("t6_we", o_mem_we, 0);      check("t6_waddr", o_mem_waddr, 0);
    check("t6_rdv", o_rd_valid, 0);   check("t6_rdaddr", o_rd_addr, 0);
    check("t6_trig", o_trig_addr, 0); check("t6_primed", o_primed, 0);
    check("t6_stopped", o_stopped, 0); check("t6_done", o_done, 0);

    ticks(2);
    check("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
